// File: rtl/lcd_capture_if.sv
// Panel bus and framebuffer write/status bundle for lcd_capture.
//   data/flm/lp/dclk/m : raw panel stream (asynchronous to the capture clock)
//   wr_en/wr_addr/wr_data : framebuffer write port, one byte per strobe
//   synced/frame_done/line_err/m_err : lock and protocol status
// master drives the panel stream, slave is the capture block.
interface lcd_capture_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [3:0]        data;
  logic              flm;
  logic              lp;
  logic              dclk;
  logic              m;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              synced;
  logic              frame_done;
  logic              line_err;
  logic              m_err;

  modport master (
    output data, flm, lp, dclk, m,
    input  wr_en, wr_addr, wr_data, synced, frame_done, line_err, m_err
  );

  modport slave (
    input  data, flm, lp, dclk, m,
    output wr_en, wr_addr, wr_data, synced, frame_done, line_err, m_err
  );
endinterface

// File: rtl/lcd_capture.sv
// Captures a raw 4-bit monochrome LCD panel stream and rebuilds the frame
// as byte writes in framebuffer layout (row * RES_X/8 + byte).
//   clk  : capture clock, at least 3x the panel nibble clock
//   rst  : synchronous active-high reset
//   bus  : lcd_capture_if.slave (panel inputs, write port, status pulses)
module lcd_capture #(
  parameter int unsigned RES_X  = 320,
  parameter int unsigned RES_Y  = 240,
  parameter int unsigned ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  lcd_capture_if.slave  bus
);
  localparam int unsigned NIBS  = RES_X / 4;
  localparam int unsigned BYTES = RES_X / 8;
  localparam int unsigned NIB_W = $clog2(NIBS + 1);
  localparam int unsigned ROW_W = (RES_Y > 1) ? $clog2(RES_Y) : 1;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LINE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Synchronizer stages, packed as {m, dclk, lp, flm, data}
  logic [7:0] s1;
  logic [7:0] s2;
  logic       lp_h;
  logic       dclk_h;

  state_t            state, state_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [NIB_W-1:0]  nib, nib_n;
  logic [3:0]        lo, lo_n;
  logic              ovf, ovf_n;
  logic              last_m, last_m_n;
  logic              synced_q, synced_n;
  logic              wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [7:0]        wr_data_q, wr_data_n;
  logic              frame_done_q, frame_done_n;
  logic              line_err_q, line_err_n;
  logic              m_err_q, m_err_n;

  logic [3:0]  d_s;
  logic [3:0]  d_swap;
  logic        flm_s, lp_s, dclk_s, m_s;
  logic        lp_fall, lp_rise, dclk_fall;
  logic [31:0] addr_full;

  assign d_s    = s2[3:0];
  assign flm_s  = s2[4];
  assign lp_s   = s2[5];
  assign dclk_s = s2[6];
  assign m_s    = s2[7];

  // Panel bit order: first pixel of a nibble sits on d[3]
  assign d_swap = {d_s[0], d_s[1], d_s[2], d_s[3]};

  assign lp_fall   = lp_h & ~lp_s;
  assign lp_rise   = ~lp_h & lp_s;
  assign dclk_fall = dclk_h & ~dclk_s;

  assign addr_full = 32'(row) * 32'(BYTES) + 32'(nib >> 1);

  // Input synchronizer and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      lp_h   <= 1'b0;
      dclk_h <= 1'b0;
    end else begin
      s1     <= {bus.m, bus.dclk, bus.lp, bus.flm, bus.data};
      s2     <= s1;
      lp_h   <= lp_s;
      dclk_h <= dclk_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_HUNT;
      row          <= '0;
      nib          <= '0;
      lo           <= '0;
      ovf          <= 1'b0;
      last_m       <= 1'b0;
      synced_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      m_err_q      <= 1'b0;
    end else begin
      state        <= state_n;
      row          <= row_n;
      nib          <= nib_n;
      lo           <= lo_n;
      ovf          <= ovf_n;
      last_m       <= last_m_n;
      synced_q     <= synced_n;
      wr_en_q      <= wr_en_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
      frame_done_q <= frame_done_n;
      line_err_q   <= line_err_n;
      m_err_q      <= m_err_n;
    end
  end

  // Next-state and output logic; lp events take priority over dclk_fall
  always_comb begin
    state_n      = state;
    row_n        = row;
    nib_n        = nib;
    lo_n         = lo;
    ovf_n        = ovf;
    last_m_n     = last_m;
    synced_n     = synced_q;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr_q;
    wr_data_n    = wr_data_q;
    frame_done_n = 1'b0;
    line_err_n   = 1'b0;
    m_err_n      = 1'b0;

    case (state)
      ST_HUNT: begin
        if (lp_fall && flm_s) begin
          row_n    = '0;
          nib_n    = '0;
          ovf_n    = 1'b0;
          last_m_n = m_s;
          synced_n = 1'b1;
          state_n  = ST_LINE;
        end
      end
      ST_LINE: begin
        if (lp_fall || lp_rise) begin
          // Line-end check; an lp_fall here also runs the line-start rules below
          if (nib != NIB_W'(NIBS) || ovf) line_err_n = 1'b1;
          state_n = ST_WAIT;
        end else if (dclk_fall) begin
          if (nib < NIB_W'(NIBS)) begin
            nib_n = nib + NIB_W'(1);
            if (!nib[0]) begin
              lo_n = d_swap;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = ADDR_W'(addr_full);
              wr_data_n = {d_swap, lo};
              if (row == ROW_W'(RES_Y - 1) && (nib >> 1) == NIB_W'(BYTES - 1))
                frame_done_n = 1'b1;
            end
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      ST_WAIT: begin
      end
      default: state_n = ST_HUNT;
    endcase

    // Line start while locked (from WAIT, or LINE with a missing lp_rise)
    if (lp_fall && state != ST_HUNT) begin
      nib_n = '0;
      ovf_n = 1'b0;
      if (flm_s) begin
        row_n = '0;
        if (m_s == last_m) m_err_n = 1'b1;
        last_m_n = m_s;
        state_n  = ST_LINE;
      end else if (row < ROW_W'(RES_Y - 1)) begin
        row_n   = row + ROW_W'(1);
        state_n = ST_LINE;
      end else begin
        line_err_n = 1'b1;
        synced_n   = 1'b0;
        state_n    = ST_HUNT;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.synced     = synced_q;
  assign bus.frame_done = frame_done_q;
  assign bus.line_err   = line_err_q;
  assign bus.m_err      = m_err_q;
endmodule
